// File: rtl/p4_router_ingress_drr_sched.sv
// Packet-granular deficit-round-robin scheduler for the P4 router ingress merge.
// Optional per-port packet counters are built when P4_ROUTER_ING_SCHED_STATS_EN is defined.
module p4_router_ingress_drr_sched #(
  parameter int NUM_PORTS     = 4,
  parameter int QUANTUM_WIDTH = 16,
  parameter int DEFICIT_WIDTH = 20
) (
  input  logic                               clk_ifc,
  input  logic                               areset_ifc,
  input  logic                               enable,
  input  logic [NUM_PORTS-1:0]               port_req,
  input  logic [NUM_PORTS*QUANTUM_WIDTH-1:0] quantum,
  input  logic                               beat_valid,
  input  logic                               beat_last,
  output logic [NUM_PORTS-1:0]               grant,
  output logic                               grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]       grant_index,
  output logic                               proto_err,
  output logic [NUM_PORTS*32-1:0]            pkt_count
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam int QW = QUANTUM_WIDTH;
  localparam int DW = DEFICIT_WIDTH;
  localparam logic signed [DW-1:0] D_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] D_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {SELECT, PKT} state_t;

  state_t               state, state_nxt;
  logic signed [DW-1:0] d [NUM_PORTS];
  logic signed [DW-1:0] d_nxt [NUM_PORTS];
  logic [IW-1:0]        ptr, ptr_nxt;
  logic [IW-1:0]        cur_nxt;
  logic [IW-1:0]        sel, sel_idx;
  logic                 new_visit, nv_nxt;
  logic                 found;
  logic                 gv_nxt, perr_nxt;
  logic [NUM_PORTS-1:0] grant_nxt;
  logic signed [DW-1:0] dsel, dbeat;

  function automatic logic signed [DW-1:0] sat_add(input logic signed [DW-1:0] a,
                                                   input logic [QW-1:0] q);
    logic signed [DW:0] s;
    s = $signed({a[DW-1], a}) + $signed({{(DW+1-QW){1'b0}}, q});
    if (s[DW] != s[DW-1]) return D_MAX;
    return s[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] sat_dec(input logic signed [DW-1:0] a);
    if (a == D_MIN) return D_MIN;
    return a - {{(DW-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic is_pos(input logic signed [DW-1:0] a);
    return !a[DW-1] && (a != '0);
  endfunction

  function automatic logic [IW-1:0] next_port(input logic [IW-1:0] i);
    if (int'(i) == NUM_PORTS - 1) return '0;
    return i + 1'b1;
  endfunction

  always_comb begin
    state_nxt = state;
    d_nxt     = d;
    ptr_nxt   = ptr;
    nv_nxt    = new_visit;
    cur_nxt   = grant_index;
    gv_nxt    = grant_valid;
    perr_nxt  = proto_err;
    found     = 1'b0;
    sel       = '0;
    sel_idx   = '0;
    dsel      = '0;
    dbeat     = '0;
    case (state)
      SELECT: begin
        // A beat with no grant is a protocol violation and is never charged.
        if (beat_valid) perr_nxt = 1'b1;
        if (enable) begin
          for (int k = 0; k < NUM_PORTS; k++) begin
            sel_idx = IW'((int'(ptr) + k) % NUM_PORTS);
            if (!found) begin
              if (port_req[sel_idx]) begin
                found = 1'b1;
                sel   = sel_idx;
              end else begin
                d_nxt[sel_idx] = '0;
              end
            end
          end
          if (found) begin
            dsel       = new_visit ? sat_add(d[sel], quantum[sel*QW +: QW]) : d[sel];
            d_nxt[sel] = dsel;
            if (is_pos(dsel)) begin
              state_nxt = PKT;
              gv_nxt    = 1'b1;
              cur_nxt   = sel;
            end else begin
              ptr_nxt = next_port(sel);
              nv_nxt  = 1'b1;
            end
          end else begin
            d_nxt = d;
          end
        end
      end
      PKT: begin
        if (beat_valid) begin
          dbeat              = sat_dec(d[grant_index]);
          d_nxt[grant_index] = dbeat;
          if (beat_last) begin
            state_nxt = SELECT;
            gv_nxt    = 1'b0;
            if (is_pos(dbeat)) begin
              ptr_nxt = grant_index;
              nv_nxt  = 1'b0;
            end else begin
              ptr_nxt = next_port(grant_index);
              nv_nxt  = 1'b1;
            end
          end
        end
      end
      default: state_nxt = SELECT;
    endcase
    grant_nxt = '0;
    if (gv_nxt) grant_nxt[cur_nxt] = 1'b1;
  end

  always_ff @(posedge clk_ifc or posedge areset_ifc) begin
    if (areset_ifc) begin
      state       <= SELECT;
      ptr         <= '0;
      new_visit   <= 1'b1;
      grant_index <= '0;
      grant_valid <= 1'b0;
      grant       <= '0;
      proto_err   <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) d[i] <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      new_visit   <= nv_nxt;
      grant_index <= cur_nxt;
      grant_valid <= gv_nxt;
      grant       <= grant_nxt;
      proto_err   <= perr_nxt;
      d           <= d_nxt;
    end
  end

`ifdef P4_ROUTER_ING_SCHED_STATS_EN
  logic [31:0] cnt [NUM_PORTS];

  always_ff @(posedge clk_ifc or posedge areset_ifc) begin
    if (areset_ifc) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
    end else if (beat_valid && beat_last) begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (grant[i]) cnt[i] <= cnt[i] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign pkt_count[g*32 +: 32] = cnt[g];
  end
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_p4_router_ingress_drr_sched.sv
// Bench for the ingress DRR scheduler: vector table, directed packet sequences and
// randomized traffic against a queue-level reference model of the scheduling rules.
module tb_p4_router_ingress_drr_sched;

  localparam int N    = 4;
  localparam int QW   = 16;
  localparam int DW   = 20;
  localparam int DMAX = (1 << (DW - 1)) - 1;
  localparam int DMIN = -(1 << (DW - 1));
`ifdef P4_ROUTER_ING_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk, rst, enable, beat_valid, beat_last;
  logic [N-1:0]    port_req, grant;
  logic [N*QW-1:0] quantum;
  logic            grant_valid, proto_err;
  logic [1:0]      grant_index;
  logic [N*32-1:0] pkt_count;

  p4_router_ingress_drr_sched #(.NUM_PORTS(N), .QUANTUM_WIDTH(QW), .DEFICIT_WIDTH(DW)) dut (
    .clk_ifc(clk), .areset_ifc(rst), .enable(enable), .port_req(port_req),
    .quantum(quantum), .beat_valid(beat_valid), .beat_last(beat_last),
    .grant(grant), .grant_valid(grant_valid), .grant_index(grant_index),
    .proto_err(proto_err), .pkt_count(pkt_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // reference model state
  int md [N];
  int mcnt [N];
  int q [N];
  int mp, mcur;
  bit mnv, mbusy, mperr;

  typedef struct {
    logic [3:0] req;
    bit         bv;
    bit         bl;
    bit         egv;
    int         ed0;
    bit         eperr;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic set_q(input int q0, input int q1, input int q2, input int q3);
    q[0] = q0; q[1] = q1; q[2] = q2; q[3] = q3;
    for (int i = 0; i < N; i++) quantum[i*QW +: QW] = QW'(q[i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin md[i] = 0; mcnt[i] = 0; end
    mp = 0; mcur = 0; mnv = 1; mbusy = 0; mperr = 0;
  endtask

  // One clock of the scheduling rules, applied to the inputs the DUT samples.
  task automatic model_step();
    int c;
    if (mbusy) begin
      if (beat_valid) begin
        if (md[mcur] > DMIN) md[mcur] = md[mcur] - 1;
        if (beat_last) begin
          mcnt[mcur]++;
          mbusy = 0;
          if (md[mcur] > 0) begin mp = mcur; mnv = 0; end
          else begin mp = (mcur + 1) % N; mnv = 1; end
        end
      end
    end else begin
      if (beat_valid) mperr = 1;
      if (enable && port_req != 0) begin
        c = mp;
        while (!port_req[c]) begin md[c] = 0; c = (c + 1) % N; end
        if (mnv) md[c] = (md[c] + q[c] > DMAX) ? DMAX : md[c] + q[c];
        if (md[c] > 0) begin mbusy = 1; mcur = c; end
        else begin mp = (c + 1) % N; mnv = 1; end
      end
    end
  endtask

  task automatic cmp_model();
    chk("grant_valid", grant_valid, mbusy);
    chk("grant_index", grant_index, mcur);
    chk("grant", grant, mbusy ? (1 << mcur) : 0);
    chk("proto_err", proto_err, mperr);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("deficit%0d", i), dut.d[i], md[i]);
      chk($sformatf("pkt_count%0d", i), pkt_count[i*32 +: 32], STATS ? mcnt[i] : 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    rst = 1'b1; port_req = '0; beat_valid = 1'b0; beat_last = 1'b0; enable = 1'b1;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_packet(input int len, output int idx, output int waited);
    waited = 0;
    while (!grant_valid && waited < 64) begin cycle(); waited++; end
    if (!grant_valid) begin
      chk("grant_timeout", 0, 1);
      idx = -1;
      return;
    end
    idx = int'(grant_index);
    for (int b = 0; b < len; b++) begin
      beat_valid = 1'b1;
      beat_last  = (b == len - 1);
      cycle();
    end
    beat_valid = 1'b0;
    beat_last  = 1'b0;
  endtask

  initial begin
    int idx, w, c0, c1, c2;
    int eq_exp [5];
    int wt_exp [10];

    eq_exp = '{0, 1, 2, 3, 0};
    wt_exp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[0]  = '{4'b0001, 0, 0, 1,  1, 0};
    tbl[1]  = '{4'b0001, 1, 0, 1,  0, 0};
    tbl[2]  = '{4'b0001, 1, 0, 1, -1, 0};
    tbl[3]  = '{4'b0001, 1, 0, 1, -2, 0};
    tbl[4]  = '{4'b0001, 1, 0, 1, -3, 0};
    tbl[5]  = '{4'b0001, 1, 1, 0, -4, 0};
    tbl[6]  = '{4'b0001, 0, 0, 0, -3, 0};
    tbl[7]  = '{4'b0001, 0, 0, 0, -2, 0};
    tbl[8]  = '{4'b0001, 0, 0, 0, -1, 0};
    tbl[9]  = '{4'b0001, 0, 0, 0,  0, 0};
    tbl[10] = '{4'b0001, 0, 0, 1,  1, 0};
    tbl[11] = '{4'b0001, 1, 1, 0,  0, 0};
    tbl[12] = '{4'b0000, 1, 0, 0,  0, 1};
    tbl[13] = '{4'b0000, 0, 0, 0,  0, 1};

    set_q(0, 0, 0, 0);
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_index", grant_index, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_pkt_count", pkt_count, 0);
    for (int i = 0; i < N; i++) chk("rst_deficit", dut.d[i], 0);

    // overdraft and stray beat, table driven
    set_q(1, 0, 0, 0);
    do_reset();
    for (int v = 0; v < 14; v++) begin
      port_req = tbl[v].req; beat_valid = tbl[v].bv; beat_last = tbl[v].bl;
      cycle();
      chk($sformatf("tbl%0d_gv", v), grant_valid, tbl[v].egv);
      chk($sformatf("tbl%0d_idx", v), grant_index, 0);
      chk($sformatf("tbl%0d_d0", v), dut.d[0], tbl[v].ed0);
      chk($sformatf("tbl%0d_perr", v), proto_err, tbl[v].eperr);
    end
    beat_valid = 1'b0; beat_last = 1'b0;

    // equal weights
    set_q(4, 4, 4, 4);
    do_reset();
    port_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      do_packet(4, idx, w);
      chk("eq_order", idx, eq_exp[n]);
      chk("eq_bubble", w, 1);
    end
    for (int i = 0; i < N; i++) chk("eq_deficit_zero", dut.d[i], 0);

    // weighted ratio
    set_q(8, 2, 0, 0);
    do_reset();
    port_req = 4'b0011;
    c0 = 0; c1 = 0; c2 = 0;
    for (int n = 0; n < 10; n++) begin
      do_packet(2, idx, w);
      chk("wt_order", idx, wt_exp[n]);
      if (idx == 0) c0++;
      if (idx == 1) c1++;
      if (idx == 2) c2++;
    end
    chk("wt_port0_pkts", c0, 8);
    chk("wt_port1_pkts", c1, 2);
    chk("wt_port2_pkts", c2, 0);

    // empty-queue forfeit
    set_q(2, 4, 0, 0);
    do_reset();
    port_req = 4'b0010;
    do_packet(1, idx, w);
    chk("ff_first_idx", idx, 1);
    chk("ff_d1_built", dut.d[1], 3);
    port_req = 4'b0001;
    do_packet(2, idx, w);
    chk("ff_second_idx", idx, 0);
    chk("ff_second_wait", w, 2);
    chk("ff_d1_forfeit", dut.d[1], 0);

    // enable drop mid-packet, stray beat, async reset mid-packet
    set_q(3, 3, 3, 3);
    do_reset();
    port_req = 4'b0001;
    cycle();
    chk("en_grant", grant_valid, 1);
    beat_valid = 1'b1; beat_last = 1'b0;
    cycle();
    enable = 1'b0;
    cycle();
    beat_last = 1'b1;
    cycle();
    beat_valid = 1'b0; beat_last = 1'b0;
    chk("en_pkt_done", grant_valid, 0);
    chk("en_d0", dut.d[0], 0);
    port_req = 4'b1111;
    repeat (5) begin cycle(); chk("en_hold", grant_valid, 0); end
    beat_valid = 1'b1;
    cycle();
    beat_valid = 1'b0;
    chk("perr_set", proto_err, 1);
    repeat (3) begin cycle(); chk("perr_sticky", proto_err, 1); end
    enable = 1'b1;
    cycle();
    chk("en_resume_gv", grant_valid, 1);
    chk("en_resume_idx", grant_index, 1);
    rst = 1'b1;
    #1;
    chk("arst_gv", grant_valid, 0);
    chk("arst_grant", grant, 0);
    chk("arst_perr", proto_err, 0);
    chk("arst_idx", grant_index, 0);
    do_reset();

    // packet counters
    set_q(0, 0, 5, 0);
    do_reset();
    port_req = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      do_packet(1, idx, w);
      chk("st_idx", idx, 2);
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("st_count%0d", i), pkt_count[i*32 +: 32], (STATS && i == 2) ? 3 : 0);

    // randomized traffic against the model
    for (int r = 0; r < 2400; r++) begin
      if (r % 600 == 0) do_reset();
      if (r % 50 == 0)
        set_q($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      enable   = ($urandom_range(0, 7) != 0);
      port_req = N'($urandom_range(0, 15));
      if (mbusy) begin
        beat_valid = ($urandom_range(0, 2) != 0);
        beat_last  = beat_valid && ($urandom_range(0, 3) == 0);
      end else begin
        beat_valid = ($urandom_range(0, 199) == 0);
        beat_last  = 1'b0;
        if (beat_valid) port_req = '0;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
